mux16_rr_sequencer: RTL and testbench



---
 rtl/mux16_rr_sequencer.sv | 112 +++++++++++
 tb/tb_mux16_rr_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/mux16_rr_sequencer.sv
// mux16_rr_sequencer
//   Round-robin scheduler that shares one 16:1 bank/lane mux among 16
//   requesters. It grants one requester at a time and holds the grant for up
//   to hold_cycles cycles (0 means 16), or less if that requester drops its
//   request. One dead cycle (GAP) follows every grant, so sel never changes
//   while en is high.
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req          request vector, bit i = requester i wants the mux
//   hold_cycles  maximum grant length (0 -> 16), sampled at arbitration only
//   sel          mux select: [3:2] bank, [1:0] lane (= granted index)
//   en           mux output enable, high only during an active grant
//   gnt          one-hot grant (1 << sel) while en is high, otherwise zero
//   busy         high in GRANT and GAP
module mux16_rr_sequencer #(
  parameter int N_REQ  = 16,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic [3:0]        sel,
  output logic              en,
  output logic [N_REQ-1:0]  gnt,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  state_e     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] ptr_q, ptr_d;
  // 5 bits so that a hold length of 16 is represented exactly
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] h_q, h_d;

  logic       found;
  logic [3:0] win;
  logic [3:0] idx;
  logic [4:0] hold_ext;
  logic       grant_end;

  // Search starts just after the last winner so it gets lowest priority.
  // k = 16 wraps to ptr itself, so a lone requester can win again.
  always_comb begin
    found = 1'b0;
    win   = 4'd0;
    idx   = 4'd0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ptr_q + 4'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign hold_ext  = (hold_cycles == '0) ? 5'd16 : 5'(hold_cycles);
  assign grant_end = !req[sel_q] || (cnt_q == h_q - 5'd1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = win;
          cnt_d   = 5'd0;
          h_d     = hold_ext;
        end
      end
      GRANT: begin
        if (grant_end) begin
          state_d = GAP;
          ptr_d   = sel_q;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 4'd0;
      ptr_q   <= 4'd15;
      cnt_q   <= 5'd0;
      h_q     <= 5'd16;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
    end
  end

  assign sel  = sel_q;
  assign en   = (state_q == GRANT);
  assign gnt  = en ? (N_REQ'(1) << sel_q) : '0;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mux16_rr_sequencer.sv
// Testbench for mux16_rr_sequencer: directed phases followed by random
// traffic, every cycle compared against a behavioural model that tracks
// grant length in elapsed cycles and searches requesters by rotation.
module tb_mux16_rr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [3:0]  hold_cycles;
  logic [3:0]  sel;
  logic        en;
  logic [15:0] gnt;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mux16_rr_sequencer dut (
    .clk(clk), .rst(rst), .req(req), .hold_cycles(hold_cycles),
    .sel(sel), .en(en), .gnt(gnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 granting, 2 gap. len = en-high cycles so far.
  int m_ph = 0, m_sel = 0, m_last = 15, m_len = 0, m_h = 16;
  int n_ph, n_sel, n_last, n_len, n_h;
  logic       prev_en = 1'b0;
  logic [3:0] prev_sel = 4'd0;

  task automatic model_next();
    n_ph = m_ph; n_sel = m_sel; n_last = m_last; n_len = m_len; n_h = m_h;
    if (rst) begin
      n_ph = 0; n_sel = 0; n_last = 15; n_len = 0; n_h = 16;
    end else if (m_ph == 0) begin
      for (int k = 1; k <= 16; k++) begin
        int c;
        c = (m_last + k) % 16;
        if (req[c] && n_ph == 0) begin
          n_ph = 1; n_sel = c; n_len = 1;
          n_h = (hold_cycles == 0) ? 16 : int'(hold_cycles);
        end
      end
    end else if (m_ph == 1) begin
      if (!req[m_sel] || m_len >= m_h) begin
        n_ph = 2; n_last = m_sel;
      end else begin
        n_len = m_len + 1;
      end
    end else begin
      n_ph = 0;
    end
  endtask

  task automatic cycle(input logic r, input logic [15:0] rq, input logic [3:0] h);
    logic [15:0] eg;
    rst = r; req = rq; hold_cycles = h;
    @(negedge clk);
    eg = (m_ph == 1) ? (16'd1 << m_sel) : 16'd0;
    chk("en",   32'(en),   32'(m_ph == 1));
    chk("sel",  32'(sel),  32'(m_sel));
    chk("gnt",  32'(gnt),  32'(eg));
    chk("busy", 32'(busy), 32'(m_ph != 0));
    if (prev_en && en) chk("sel_stable", 32'(sel), 32'(prev_sel));
    if (en) chk("gnt_onehot", 32'(gnt), 32'(16'd1 << sel));
    prev_en = en; prev_sel = sel;
    model_next();
    @(posedge clk);
    #1;
    m_ph = n_ph; m_sel = n_sel; m_last = n_last; m_len = n_len; m_h = n_h;
  endtask

  initial begin
    rst = 1'b1; req = '0; hold_cycles = '0;
    repeat (2) @(posedge clk);
    #1;
    // reset then single request
    repeat (2) cycle(1'b1, 16'h0000, 4'd3);
    repeat (14) cycle(1'b0, 16'h0004, 4'd3);
    repeat (4) cycle(1'b0, 16'h0000, 4'd3);
    // round robin with wrap
    repeat (14) cycle(1'b0, 16'h8001, 4'd1);
    repeat (4) cycle(1'b0, 16'h0000, 4'd1);
    // early release: idle cycle + 2 grant cycles, then drop
    repeat (3) cycle(1'b0, 16'h0020, 4'd8);
    repeat (6) cycle(1'b0, 16'h0000, 4'd8);
    // hold 0 means 16
    repeat (40) cycle(1'b0, 16'h0100, 4'd0);
    repeat (4) cycle(1'b0, 16'h0000, 4'd0);
    // mid-grant input changes and reset
    repeat (3) cycle(1'b0, 16'h0808, 4'd6);
    repeat (3) cycle(1'b0, 16'h0809, 4'd2);
    cycle(1'b1, 16'h0808, 4'd2);
    repeat (12) cycle(1'b0, 16'h0808, 4'd2);
    repeat (4) cycle(1'b0, 16'h0000, 4'd2);
    // all requesting
    repeat (100) cycle(1'b0, 16'hFFFF, 4'd2);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] rq;
      rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 3) == 0) rq = req;
      cycle(($urandom_range(0, 63) == 0), rq, 4'($urandom_range(0, 15)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
